// File: rtl/context_shadow_stack_if.sv
// ----------------------------------------------------------------------------
// context_shadow_stack_if
// Bundles the signals between the core and the context shadow stack.
//   master modport : core side. Drives the live context, trap controls,
//                    restore_ready and clear_err. Observes all outputs.
//   slave modport  : stack side (the context_shadow_stack module).
// Signal names use i_/o_ as seen from the stack.
//   i_ctx_in        live register values, channel 0 in the LSBs
//   i_in_kernel     core is executing kernel code
//   i_enter         trap pulse (push)
//   i_leave         kernel-return pulse (pop)
//   i_restore_ready consumer accepts o_restore_out
//   i_clear_err     clears the sticky error flags
//   o_live_out      current shadow snapshot
//   o_restore_out   popped context, held while o_restore_valid
//   o_restore_valid o_restore_out is valid
//   o_level         number of stacked contexts
//   o_busy          restore in progress
//   o_overflow / o_underflow / o_protocol_err   sticky error flags
// ----------------------------------------------------------------------------
interface context_shadow_stack_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
);
    localparam int DW = WIDTH * CHANNELS;
    localparam int LW = $clog2(DEPTH + 1);

    logic [DW-1:0] i_ctx_in;
    logic          i_in_kernel;
    logic          i_enter;
    logic          i_leave;
    logic          i_restore_ready;
    logic          i_clear_err;
    logic [DW-1:0] o_live_out;
    logic [DW-1:0] o_restore_out;
    logic          o_restore_valid;
    logic [LW-1:0] o_level;
    logic          o_busy;
    logic          o_overflow;
    logic          o_underflow;
    logic          o_protocol_err;

    modport master (
        output i_ctx_in, i_in_kernel, i_enter, i_leave, i_restore_ready, i_clear_err,
        input  o_live_out, o_restore_out, o_restore_valid, o_level, o_busy,
               o_overflow, o_underflow, o_protocol_err
    );

    modport slave (
        input  i_ctx_in, i_in_kernel, i_enter, i_leave, i_restore_ready, i_clear_err,
        output o_live_out, o_restore_out, o_restore_valid, o_level, o_busy,
               o_overflow, o_underflow, o_protocol_err
    );
endinterface

// File: rtl/context_shadow_stack.sv
// ----------------------------------------------------------------------------
// context_shadow_stack
// Shadows CHANNELS user registers while the core runs user code, pushes the
// snapshot onto a DEPTH-entry LIFO on every trap entry and hands the saved
// context back through a valid/ready handshake on kernel return.
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  synchronous, active-low reset
//   bus      context_shadow_stack_if.slave (see interface header)
// ----------------------------------------------------------------------------
module context_shadow_stack #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    context_shadow_stack_if.slave  bus
);
    localparam int DW = WIDTH * CHANNELS;
    localparam int LW = $clog2(DEPTH + 1);
    // Index width for the stack array; at least one bit so DEPTH=1 works.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_RESTORE
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_live;
    logic [DW-1:0] r_stack [DEPTH];
    logic [DW-1:0] r_restore;
    logic          r_valid;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_protocol_err;

    logic [DW-1:0] w_snapshot;
    logic [LW-1:0] w_level_m1;
    logic [IW-1:0] w_push_idx;
    logic [IW-1:0] w_pop_idx;
    logic          w_idle;
    logic          w_full;
    logic          w_empty;
    logic          w_set_ovf;
    logic          w_set_udf;
    logic          w_set_perr;

    // The snapshot equals what r_live holds after this edge, so an enter on
    // the same edge that in_kernel rises saves the last user-mode state.
    assign w_snapshot = bus.i_in_kernel ? r_live : bus.i_ctx_in;

    assign w_level_m1 = r_level - LW'(1);
    assign w_push_idx = r_level[IW-1:0];
    assign w_pop_idx  = w_level_m1[IW-1:0];
    assign w_idle     = (r_state == S_IDLE);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_empty    = (r_level == '0);

    assign w_set_ovf  = w_idle && bus.i_enter && !bus.i_leave && w_full;
    assign w_set_udf  = w_idle && bus.i_leave && !bus.i_enter && w_empty;
    assign w_set_perr = w_idle ? (bus.i_enter && bus.i_leave)
                               : (bus.i_enter || bus.i_leave);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_live         <= '0;
            // NOTE: the stack array is reset entry by entry because reset must
            // leave every entry at zero; with small DEPTH this stays cheap.
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_restore      <= '0;
            r_valid        <= 1'b0;
            r_level        <= '0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            if (!bus.i_in_kernel) begin
                r_live <= bus.i_ctx_in;
            end

            // Setting an error flag wins over a simultaneous clear.
            r_overflow     <= w_set_ovf  || (r_overflow     && !bus.i_clear_err);
            r_underflow    <= w_set_udf  || (r_underflow    && !bus.i_clear_err);
            r_protocol_err <= w_set_perr || (r_protocol_err && !bus.i_clear_err);

            case (r_state)
                S_IDLE: begin
                    if (bus.i_enter && !bus.i_leave && !w_full) begin
                        r_stack[w_push_idx] <= w_snapshot;
                        r_level             <= r_level + LW'(1);
                    end else if (bus.i_leave && !bus.i_enter && !w_empty) begin
                        // Level drops only at the handshake, so an aborted
                        // restore (reset) never loses a stacked context early.
                        r_restore <= r_stack[w_pop_idx];
                        r_valid   <= 1'b1;
                        r_state   <= S_RESTORE;
                    end
                end
                S_RESTORE: begin
                    if (bus.i_restore_ready) begin
                        r_level <= w_level_m1;
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_live_out      = r_live;
    assign bus.o_restore_out   = r_restore;
    assign bus.o_restore_valid = r_valid;
    assign bus.o_level         = r_level;
    assign bus.o_busy          = (r_state == S_RESTORE);
    assign bus.o_overflow      = r_overflow;
    assign bus.o_underflow     = r_underflow;
    assign bus.o_protocol_err  = r_protocol_err;

endmodule

// File: tb/tb_context_shadow_stack.sv
// ----------------------------------------------------------------------------
// tb_context_shadow_stack
// Directed table of cycle vectors with hand-derived expectations, followed by
// randomized cycles compared against a queue-based behavioural model.
// ----------------------------------------------------------------------------
module tb_context_shadow_stack;
    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 4;
    localparam int DW       = WIDTH * CHANNELS;
    localparam int LW       = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;

    context_shadow_stack_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus ();

    context_shadow_stack #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors    = 0;
    int n_miscompares = 0;

    typedef struct {
        logic          rst;
        logic [DW-1:0] ctx;
        logic          ik, en, lv, rdy, clr;
        logic [DW-1:0] e_live;
        logic [DW-1:0] e_rest;
        logic          e_valid;
        logic [LW-1:0] e_level;
        logic [2:0]    e_flags;   // {overflow, underflow, protocol_err}
    } vec_t;

    vec_t tbl[$];

    // Behavioural reference: the stack is a plain queue, top at the back.
    logic [DW-1:0] m_stack[$];
    logic [DW-1:0] m_live, m_rest;
    logic          m_valid, m_ovf, m_udf, m_perr;

    function automatic logic [DW-1:0] rep(input logic [WIDTH-1:0] v);
        return {CHANNELS{v}};
    endfunction

    function automatic void add(input logic rst, input logic [DW-1:0] ctx,
                                input logic ik, en, lv, rdy, clr,
                                input logic [DW-1:0] e_live, e_rest,
                                input logic e_valid, input int e_level,
                                input logic [2:0] e_flags);
        vec_t v;
        v.rst = rst; v.ctx = ctx; v.ik = ik; v.en = en; v.lv = lv;
        v.rdy = rdy; v.clr = clr; v.e_live = e_live; v.e_rest = e_rest;
        v.e_valid = e_valid; v.e_level = LW'(e_level); v.e_flags = e_flags;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int step,
                         input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [DW-1:0] ctx,
                         input logic ik, en, lv, rdy, clr);
        rst_n               = rst;
        bus.i_ctx_in        = ctx;
        bus.i_in_kernel     = ik;
        bus.i_enter         = en;
        bus.i_leave         = lv;
        bus.i_restore_ready = rdy;
        bus.i_clear_err     = clr;
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic so, su, sp;
        so = 1'b0; su = 1'b0; sp = 1'b0;
        if (!rst_n) begin
            m_stack.delete();
            m_live = '0; m_rest = '0; m_valid = 1'b0;
            m_ovf = 1'b0; m_udf = 1'b0; m_perr = 1'b0;
        end else begin
            if (m_valid) begin
                if (bus.i_enter || bus.i_leave) sp = 1'b1;
                if (bus.i_restore_ready) begin
                    void'(m_stack.pop_back());
                    m_valid = 1'b0;
                end
            end else if (bus.i_enter && bus.i_leave) begin
                sp = 1'b1;
            end else if (bus.i_enter) begin
                if (m_stack.size() < DEPTH)
                    m_stack.push_back(bus.i_in_kernel ? m_live : bus.i_ctx_in);
                else
                    so = 1'b1;
            end else if (bus.i_leave) begin
                if (m_stack.size() > 0) begin
                    m_rest  = m_stack[m_stack.size()-1];
                    m_valid = 1'b1;
                end else begin
                    su = 1'b1;
                end
            end
            m_ovf  = so || (m_ovf  && !bus.i_clear_err);
            m_udf  = su || (m_udf  && !bus.i_clear_err);
            m_perr = sp || (m_perr && !bus.i_clear_err);
            if (!bus.i_in_kernel) m_live = bus.i_ctx_in;
        end
    endtask

    task automatic check_all(input int step, input logic [DW-1:0] e_live,
                             input logic [DW-1:0] e_rest, input logic e_valid,
                             input logic [LW-1:0] e_level, input logic [2:0] e_flags);
        check("live_out",      step, bus.o_live_out, e_live);
        check("restore_out",   step, bus.o_restore_out, e_rest);
        check("restore_valid", step, DW'(bus.o_restore_valid), DW'(e_valid));
        check("busy",          step, DW'(bus.o_busy), DW'(e_valid));
        check("level",         step, DW'(bus.o_level), DW'(e_level));
        check("flags",         step,
              DW'({bus.o_overflow, bus.o_underflow, bus.o_protocol_err}), DW'(e_flags));
    endtask

    initial begin
        logic [DW-1:0] c_r, c_a, c1, c2, c3, c4, c5;
        c_r = 64'h1111_2222_3333_4444;
        c_a = 64'hAAAA_BBBB_CCCC_DDDD;
        c1 = rep(16'h0001); c2 = rep(16'h0002); c3 = rep(16'h0003);
        c4 = rep(16'h0004); c5 = rep(16'h0005);

        //   rst ctx  ik en lv rdy clr | live rest val lvl flags
        // Reset, then release with in_kernel low.
        add(0, c_r, 0, 0, 0, 0, 0,   '0,  '0,  0, 0, 3'b000);
        add(0, c_r, 0, 0, 0, 0, 0,   '0,  '0,  0, 0, 3'b000);
        add(1, c_r, 0, 0, 0, 0, 0,   c_r, '0,  0, 0, 3'b000);
        // Single trap: enter on the in_kernel rising edge saves the user state.
        add(1, c_a, 0, 0, 0, 0, 0,   c_a, '0,  0, 0, 3'b000);
        add(1, c_a, 1, 1, 0, 0, 0,   c_a, '0,  0, 1, 3'b000);
        add(1, '0,  1, 0, 0, 0, 0,   c_a, '0,  0, 1, 3'b000);
        add(1, '0,  1, 0, 1, 1, 0,   c_a, c_a, 1, 1, 3'b000);
        add(1, '0,  1, 0, 0, 1, 0,   c_a, c_a, 0, 0, 3'b000);
        // Nest to full, then a fifth enter overflows.
        add(1, c1,  0, 1, 0, 0, 0,   c1,  c_a, 0, 1, 3'b000);
        add(1, c2,  0, 1, 0, 0, 0,   c2,  c_a, 0, 2, 3'b000);
        add(1, c3,  0, 1, 0, 0, 0,   c3,  c_a, 0, 3, 3'b000);
        add(1, c4,  0, 1, 0, 0, 0,   c4,  c_a, 0, 4, 3'b000);
        add(1, c5,  0, 1, 0, 0, 0,   c5,  c_a, 0, 4, 3'b100);
        // First pop under five cycles of backpressure.
        add(1, '0,  1, 0, 1, 0, 0,   c5,  c4,  1, 4, 3'b100);
        for (int i = 0; i < 5; i++)
            add(1, '0, 1, 0, 0, 0, 0, c5, c4,  1, 4, 3'b100);
        add(1, '0,  1, 0, 0, 1, 0,   c5,  c4,  0, 3, 3'b100);
        add(1, '0,  1, 0, 1, 1, 0,   c5,  c3,  1, 3, 3'b100);
        add(1, '0,  1, 0, 0, 1, 0,   c5,  c3,  0, 2, 3'b100);
        add(1, '0,  1, 0, 1, 1, 0,   c5,  c2,  1, 2, 3'b100);
        add(1, '0,  1, 0, 0, 1, 0,   c5,  c2,  0, 1, 3'b100);
        add(1, '0,  1, 0, 1, 1, 0,   c5,  c1,  1, 1, 3'b100);
        add(1, '0,  1, 0, 0, 1, 0,   c5,  c1,  0, 0, 3'b100);
        // Error flags.
        add(1, '0,  1, 0, 0, 0, 1,   c5,  c1,  0, 0, 3'b000);
        add(1, '0,  1, 0, 1, 0, 0,   c5,  c1,  0, 0, 3'b010);
        add(1, c1,  0, 1, 0, 0, 0,   c1,  c1,  0, 1, 3'b010);
        add(1, c1,  0, 1, 1, 0, 0,   c1,  c1,  0, 1, 3'b011);
        add(1, c2,  1, 0, 1, 0, 0,   c1,  c1,  1, 1, 3'b011);
        add(1, c2,  1, 1, 0, 0, 0,   c1,  c1,  1, 1, 3'b011);
        add(1, c2,  1, 0, 0, 1, 1,   c1,  c1,  0, 0, 3'b000);
        add(1, c2,  1, 0, 1, 0, 1,   c1,  c1,  0, 0, 3'b010);
        add(1, c2,  1, 0, 0, 0, 1,   c1,  c1,  0, 0, 3'b000);
        // Reset during a restore discards the pending pop.
        add(1, c1,  0, 1, 0, 0, 0,   c1,  c1,  0, 1, 3'b000);
        add(1, c2,  0, 1, 0, 0, 0,   c2,  c1,  0, 2, 3'b000);
        add(1, c3,  1, 0, 1, 0, 0,   c2,  c2,  1, 2, 3'b000);
        add(1, c3,  1, 0, 0, 0, 0,   c2,  c2,  1, 2, 3'b000);
        add(0, c3,  1, 0, 0, 0, 0,   '0,  '0,  0, 0, 3'b000);
        add(1, c3,  0, 0, 0, 1, 0,   c3,  '0,  0, 0, 3'b000);
        add(1, c3,  0, 0, 1, 1, 0,   c3,  '0,  0, 0, 3'b010);
        add(1, c3,  0, 0, 0, 0, 1,   c3,  '0,  0, 0, 3'b000);

        drive(0, '0, 0, 0, 0, 0, 0);
        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ctx, tbl[i].ik, tbl[i].en, tbl[i].lv,
                  tbl[i].rdy, tbl[i].clr);
            @(posedge clk);
            model_step();
            #1;
            check_all(i, tbl[i].e_live, tbl[i].e_rest, tbl[i].e_valid,
                      tbl[i].e_level, tbl[i].e_flags);
        end

        // Randomized cycles against the reference model.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(99) != 0,
                  {$urandom, $urandom},
                  $urandom_range(1),
                  $urandom_range(5) == 0,
                  $urandom_range(5) == 0,
                  $urandom_range(1),
                  $urandom_range(15) == 0);
            @(posedge clk);
            model_step();
            #1;
            check_all(1000 + i, m_live, m_rest, m_valid,
                      LW'(m_stack.size()), {m_ovf, m_udf, m_perr});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/context_shadow_stack.md
Name: context_shadow_stack

Overview:
- Parametrised successor to the kernel-mode shadow register bank.
- Continuously shadows CHANNELS user-visible registers (mary, shelley, comp, ra, ...) while the core is outside the kernel.
- Pushes the snapshot onto a DEPTH-entry stack on each kernel entry, so nested traps are supported.
- On kernel exit, pops and returns the saved context through a valid/ready restore handshake. Overflow, underflow and protocol errors are flagged.

Parameters:
- WIDTH, 16, bits per channel.
- CHANNELS, 4, number of shadowed registers. Channel 0 occupies the LSBs of every packed bus.
- DEPTH, 4, maximum nesting levels, ≥1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- ctx_in  in  CHANNELS*WIDTH  live register values, packed.
- in_kernel  in  1  high while the core executes kernel code.
- enter  in  1  one-cycle pulse: trap taken, push context.
- leave  in  1  one-cycle pulse: kernel return, pop context.
- restore_ready  in  1  consumer accepts restore_out.
- clear_err  in  1  clears the sticky error flags.
- live_out  out  CHANNELS*WIDTH  current shadow snapshot.
- restore_out  out  CHANNELS*WIDTH  popped context; stable while restore_valid=1.
- restore_valid  out  1  restore_out is valid.
- level  out  $clog2(DEPTH+1)  current number of stacked contexts.
- busy  out  1  high in the RESTORE state.
- overflow  out  1  sticky error flag.
- underflow  out  1  sticky error flag.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (reset=0 at an edge):
  - live_out, all stack entries, restore_out, level, restore_valid, busy and all flags go to 0.
  - State goes to IDLE.
  - Reset overrides every other input, including mid-restore: restore_valid is 0 the cycle after and the pending pop is discarded.
- Live shadow:
  - in_kernel=0 at an edge: live register <= ctx_in.
  - in_kernel=1: live register holds.
  - live_out = live register; no added latency.
- Push snapshot value: in_kernel=0 ? ctx_in : live register. This is the value the live register holds after the same edge, so an enter coincident with the rising edge of in_kernel saves the last user state.
- FSM, state IDLE:
  - enter=1, leave=0, level<DEPTH: stack[level] <= snapshot; level <= level+1.
  - enter=1, leave=0, level==DEPTH: no push; overflow <= 1.
  - leave=1, enter=0, level>0: restore_out <= stack[level-1]; restore_valid <= 1; go to RESTORE. Latency is one cycle: valid from the cycle after leave.
  - leave=1, enter=0, level==0: underflow <= 1; stay in IDLE.
  - enter=1 and leave=1 together: neither action is performed; protocol_err <= 1.
- FSM, state RESTORE (busy=1):
  - restore_out and restore_valid are held until restore_ready=1.
  - On the edge with restore_valid=1 and restore_ready=1: level <= level-1; restore_valid <= 0; go to IDLE.
  - The earliest next leave is accepted the cycle after returning to IDLE.
  - enter or leave asserted in RESTORE: ignored; protocol_err <= 1.
  - The live shadow continues to operate in this state.
- Stack discipline:
  - Strict LIFO.
  - Entries at indices ≥ level are don't-care; they are not cleared on pop.
- Error flags:
  - overflow, underflow and protocol_err are sticky.
  - They are cleared by clear_err=1 at an edge.
  - Setting takes priority over clear_err in the same cycle.
  - Flags never block normal operation.
- Width rule: level saturates; it never wraps past DEPTH or below 0.

Test Plan:
- Reset then idle: reset=0 for 2 cycles with ctx_in=0x1111_2222_3333_4444 → all outputs 0. Release reset with in_kernel=0 → live_out equals ctx_in after 1 edge.
- Single trap: with ctx_in=0xAAAA_BBBB_CCCC_DDDD, raise in_kernel and pulse enter on the same edge. Change ctx_in to 0x0 → level=1, live_out holds 0xAAAA_BBBB_CCCC_DDDD. Pulse leave with restore_ready=1 → restore_valid=1 the next cycle with that value; level=0 one cycle later.
- Nesting to full (DEPTH=4): push contexts 0x0001..0x0004 (replicated per channel), then a 5th enter → level=4, overflow=1. Four pops return 0x0004, 0x0003, 0x0002, 0x0001 in order.
- Backpressure: hold restore_ready=0 for 5 cycles after leave → restore_valid and restore_out stable, busy=1, level unchanged. Assert ready → level decrements on that edge.
- Errors: leave at level=0 → underflow=1. enter and leave on the same cycle → protocol_err=1, level unchanged. enter during RESTORE → protocol_err=1, no push. clear_err → all flags 0.
- Reset mid-restore: level=2, leave, then reset=0 while restore_valid=1 → next cycle restore_valid=0, level=0, state IDLE.
